// File: rtl/efuses_read_sm.sv
// rtl/efuses_read_sm.sv - eFuse macro serial read-out controller
// Drives CSB/SCLK through a 32-bit read and captures DOUT LSB-first.
module efuses_read_sm #(
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  TCKHP,
  input  logic        DOUT,
  output logic        CSB,
  output logic        SCLK,
  output logic        PGM,
  output logic [31:0] data,
  output logic        valid,
  output logic        busy
);

  // cnt must cover a full half period as well as the setup/hold preloads
  localparam int CMAX_A = (SETUP_CYC - 1 > 15) ? SETUP_CYC - 1 : 15;
  localparam int CMAX   = (HOLD_CYC - 1 > CMAX_A) ? HOLD_CYC - 1 : CMAX_A;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_HI = 3'd2,
    SCLK_LO = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    hp;
  logic [4:0]    bit_cnt;
  logic [31:0]   shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hp      <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      CSB     <= 1'b1;
      SCLK    <= 1'b0;
      PGM     <= 1'b0;
      data    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      PGM   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            CSB     <= 1'b0;
            busy    <= 1'b1;
            hp      <= TCKHP;
            bit_cnt <= '0;
            cnt     <= SETUP_LD;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            SCLK  <= 1'b1;
            cnt   <= CW'(hp);
            state <= SCLK_HI;
          end
        end
        SCLK_HI: begin
          // DOUT is captured on the edge that drops SCLK (last high cycle)
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            shift[bit_cnt] <= DOUT;
            SCLK           <= 1'b0;
            cnt            <= CW'(hp);
            state          <= SCLK_LO;
          end
        end
        SCLK_LO: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (bit_cnt == 5'd31) begin
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            SCLK    <= 1'b1;
            cnt     <= CW'(hp);
            state   <= SCLK_HI;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            CSB   <= 1'b1;
            data  <= shift;
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          hp      <= '0;
          bit_cnt <= '0;
          shift   <= '0;
          CSB     <= 1'b1;
          SCLK    <= 1'b0;
          data    <= '0;
          valid   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_efuses_read_sm.sv
// tb/tb_efuses_read_sm.sv - self-checking bench for efuses_read_sm
// Table of reads (directed + random) checked against a timing/data model.
module tb_efuses_read_sm;

  localparam int SETUP_CYC = 4;
  localparam int HOLD_CYC  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  TCKHP;
  logic        DOUT;
  logic        CSB, SCLK, PGM, valid, busy;
  logic [31:0] data;

  int errors = 0;
  int checks = 0;
  int pgm_bad = 0;

  efuses_read_sm #(.SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .TCKHP(TCKHP), .DOUT(DOUT),
    .CSB(CSB), .SCLK(SCLK), .PGM(PGM), .data(data), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (PGM !== 1'b0) pgm_bad++;

  typedef struct {
    logic [3:0]  hp;
    logic [31:0] word;
    int          mode;     // 0 plain, 1 spurious start + TCKHP change mid-read
    bit          b2b;      // next read starts in the cycle right after valid
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  // Reference: setup, 32 bits of (high + low) half periods, hold.
  function automatic int ref_lat(input logic [3:0] hp);
    return SETUP_CYC + 64 * (int'(hp) + 1) + HOLD_CYC;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues a start, plays the DOUT model, and returns at the negedge where valid
  // is seen (or where rst was applied for mode 2).
  task automatic do_read(input logic [3:0] hp, input logic [31:0] word,
                         input int mode, input int exp_lat);
    int k, rises, hi_run, lo_run;
    bit width_bad, seen_valid, prev;
    start = 1'b1;
    TCKHP = hp;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    check("accept_busy", busy, 1);
    check("accept_csb", CSB, 0);
    check("valid_cleared", valid, 0);
    rises = 0; hi_run = 0; lo_run = 0;
    width_bad = 0; seen_valid = 0; prev = SCLK;
    while (!seen_valid && k < 1100) begin
      @(negedge clk);
      k++;
      if (mode == 1 && k == 50) begin
        start = 1'b1;
        TCKHP = 4'd9;
      end
      if (mode == 1 && k == 51) start = 1'b0;
      if (mode == 2 && k == 100) break;
      if (SCLK && !prev) begin
        if (rises > 0 && lo_run != int'(hp) + 1) width_bad = 1;
        rises++;
        if (rises <= 32) DOUT = word[rises-1];
        hi_run = 1;
      end else if (SCLK) begin
        hi_run++;
      end else if (prev) begin
        if (hi_run != int'(hp) + 1) width_bad = 1;
        lo_run = 1;
      end else begin
        lo_run++;
      end
      prev = SCLK;
      if (valid) seen_valid = 1;
    end
    if (mode == 2) begin
      check("midrst_no_valid_before", seen_valid, 0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_csb", CSB, 1);
      check("midrst_sclk", SCLK, 0);
      check("midrst_busy", busy, 0);
      check("midrst_data", data, 0);
      rst = 1'b0;
      seen_valid = 0;
      repeat (40) begin
        @(negedge clk);
        if (valid || !CSB || SCLK) seen_valid = 1;
      end
      check("midrst_quiet", seen_valid, 0);
    end else begin
      check("valid_seen", seen_valid, 1);
      check("latency", k, exp_lat);
      check("data", data, word);
      check("csb_at_valid", CSB, 1);
      check("busy_at_valid", busy, 0);
      check("sclk_rises", rises, 32);
      check("sclk_widths", width_bad, 0);
    end
  endtask

  initial begin
    bit idle_bad;
    rst = 1'b1; start = 1'b1; TCKHP = 4'd0; DOUT = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_csb", CSB, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_pgm", PGM, 0);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_after_rst", busy, 0);

    vecs[0] = '{hp: 4'd4,  word: 32'hA5C3_0F81, mode: 0, b2b: 1, exp_lat: 328};
    vecs[1] = '{hp: 4'd0,  word: 32'hFFFF_0000, mode: 0, b2b: 0, exp_lat: 72};
    vecs[2] = '{hp: 4'd4,  word: 32'h1234_5678, mode: 1, b2b: 0, exp_lat: 328};
    vecs[3] = '{hp: 4'd15, word: 32'h0F0F_1234, mode: 0, b2b: 0, exp_lat: 1032};
    for (int i = 4; i < 10; i++) begin
      vecs[i].hp      = 4'($urandom_range(0, 15));
      vecs[i].word    = $urandom;
      vecs[i].mode    = 0;
      vecs[i].b2b     = 1'($urandom_range(0, 1));
      vecs[i].exp_lat = ref_lat(vecs[i].hp);
    end

    for (int i = 0; i < 10; i++) begin
      do_read(vecs[i].hp, vecs[i].word, vecs[i].mode, vecs[i].exp_lat);
      if (vecs[i].mode == 1) begin
        idle_bad = 0;
        repeat (10) begin
          @(negedge clk);
          if (busy || !CSB || SCLK) idle_bad = 1;
        end
        check("no_second_read", idle_bad, 0);
      end else if (!vecs[i].b2b) begin
        repeat (3) @(negedge clk);
      end
    end

    do_read(4'd4, 32'hDEAD_BEEF, 2, 0);
    check("pgm_never_high", pgm_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
